// File: rtl/hsem_lock_master_pkg.sv
// Shared definitions for the HSEM lock master: AHB encodings, RESOURCE register layout
// (LOCK bit, COREID field, word stride) and the FSM state codes.
package hsem_lock_master_pkg;

    localparam int AHB_DATA_WIDTH = 32;
    localparam int LOCK_BIT       = 31;
    localparam int COREID_MSB     = 7;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_A    = 3'd1,
        S_WR_D    = 3'd2,
        S_RD_A    = 3'd3,
        S_RD_D    = 3'd4,
        S_BACKOFF = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // RESOURCE_n registers sit on consecutive words: offsets 0x00..0x1C.
    function automatic logic [AHB_DATA_WIDTH-1:0] resource_offset(input logic [2:0] n);
        return {{(AHB_DATA_WIDTH-5){1'b0}}, n, 2'b00};
    endfunction

    function automatic logic [AHB_DATA_WIDTH-1:0] lock_word(input logic lock, input logic [7:0] core);
        logic [AHB_DATA_WIDTH-1:0] w;
        w                 = '0;
        w[LOCK_BIT]       = lock;
        w[COREID_MSB:0]   = core;
        return w;
    endfunction

    // Only LOCK and COREID take part in the ownership check.
    localparam logic [AHB_DATA_WIDTH-1:0] OWNER_MASK = lock_word(1'b1, 8'hFF);

endpackage

// File: rtl/hsem_lock_master.sv
// AHB-Lite initiator that locks/unlocks HSEM RESOURCE_n semaphores for the local core.
// Optional HSEM_MASTER_IRQ_WAIT_EN adds sem_free_irq to cut the retry backoff short.
module hsem_lock_master
    import hsem_lock_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]  CORE_ID     = 8'h01,
    parameter int          MAX_RETRY   = 8,
    parameter int          BACKOFF_CYC = 16
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      lock_req,
    input  logic                      unlock_req,
    input  logic [2:0]                sem_id,
    output logic                      busy,
    output logic                      done,
    output logic                      granted,
    output logic                      err,
    output logic [AHB_DATA_WIDTH-1:0] haddr,
    output logic [1:0]                htrans,
    output logic                      hwrite,
    output logic [2:0]                hsize,
    output logic [AHB_DATA_WIDTH-1:0] hwdata,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata,
    input  logic                      hready,
`ifdef HSEM_MASTER_IRQ_WAIT_EN
    input  logic                      sem_free_irq,
`endif
    input  logic                      hresp
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int BW = $clog2(BACKOFF_CYC + 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [2:0]                sem_q;
    logic                      op_lock_q;
    logic [RW-1:0]             retry_cnt;
    logic [BW-1:0]             bo_cnt;
    logic                      granted_q;
    logic                      err_q;
    logic                      accept;
    logic                      rd_owned;
    logic                      last_try;
    logic                      bo_leave;
    logic [AHB_DATA_WIDTH-1:0] sem_addr;

    assign accept   = (state == S_IDLE) && (lock_req || unlock_req);
    assign rd_owned = (hrdata & OWNER_MASK) == lock_word(1'b1, CORE_ID);
    assign last_try = (retry_cnt == RW'(MAX_RETRY - 1));
    assign sem_addr = BASE_ADDR + resource_offset(sem_q);

`ifdef HSEM_MASTER_IRQ_WAIT_EN
    assign bo_leave = (bo_cnt == BW'(BACKOFF_CYC - 1)) || sem_free_irq;
`else
    assign bo_leave = (bo_cnt == BW'(BACKOFF_CYC - 1));
`endif

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Any error cycle in a data phase aborts straight to DONE; no further transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_WR_A;
            end
            S_WR_A: begin
                if (hready) state_nxt = S_WR_D;
            end
            S_WR_D: begin
                if (hresp)       state_nxt = S_DONE;
                else if (hready) state_nxt = op_lock_q ? S_RD_A : S_DONE;
            end
            S_RD_A: begin
                if (hready) state_nxt = S_RD_D;
            end
            S_RD_D: begin
                if (hresp) begin
                    state_nxt = S_DONE;
                end else if (hready) begin
                    if (rd_owned || last_try) state_nxt = S_DONE;
                    else                      state_nxt = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                if (bo_leave) state_nxt = S_WR_A;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        haddr  = '0;
        hwdata = '0;
        case (state)
            S_WR_A: begin
                htrans = HTRANS_NONSEQ;
                hwrite = 1'b1;
                haddr  = sem_addr;
            end
            S_WR_D: begin
                hwdata = lock_word(op_lock_q, CORE_ID);
            end
            S_RD_A: begin
                htrans = HTRANS_NONSEQ;
                haddr  = sem_addr;
            end
            default: begin
                htrans = HTRANS_IDLE;
            end
        endcase
    end

    assign hsize   = HSIZE_WORD;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign granted = granted_q;
    assign err     = err_q;

    // Request capture: unlock wins when both requests arrive together.
    always_ff @(posedge hclk) begin
        if (accept) begin
            sem_q     <= sem_id;
            op_lock_q <= !unlock_req;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            granted_q <= 1'b0;
            err_q     <= 1'b0;
            retry_cnt <= '0;
            bo_cnt    <= '0;
        end else begin
            if (accept) begin
                granted_q <= 1'b0;
                err_q     <= 1'b0;
                retry_cnt <= '0;
            end
            if (((state == S_WR_D) || (state == S_RD_D)) && hresp) begin
                err_q <= 1'b1;
            end
            if ((state == S_RD_D) && !hresp && hready) begin
                if (rd_owned) granted_q <= 1'b1;
                else          retry_cnt <= retry_cnt + 1'b1;
            end
            bo_cnt <= ((state == S_BACKOFF) && (state_nxt == S_BACKOFF)) ? bo_cnt + 1'b1 : '0;
        end
    end

endmodule
